bp_fe_bp_bimodal: RTL and testbench

BP_FE_BP_BIMODAL -- requirements
Module: bp_fe_bp_bimodal

---
 rtl/bp_fe_bp_bimodal.sv | 105 ++++++++++
 tb/tb_bp_fe_bp_bimodal.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bp_fe_bp_bimodal.sv
// rtl/bp_fe_bp_bimodal.sv - bimodal branch history table of saturating counters
module bp_fe_bp_bimodal #(
    parameter int bht_idx_width_p = 9,
    parameter int ctr_width_p     = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,

    input  logic                       r_v_i,
    input  logic [bht_idx_width_p-1:0] idx_r_i,
    output logic                       predict_o,
    output logic                       predict_v_o,

    input  logic                       w_v_i,
    input  logic [bht_idx_width_p-1:0] idx_w_i,
    input  logic                       taken_i,
    output logic                       w_yumi_o,

    output logic                       init_done_o
);

    localparam int els_lp = 1 << bht_idx_width_p;
    localparam logic [ctr_width_p-1:0] ctr_init_lp = ctr_width_p'((1 << (ctr_width_p - 1)) - 1);
    localparam logic [ctr_width_p-1:0] ctr_max_lp  = {ctr_width_p{1'b1}};
    localparam logic [ctr_width_p-1:0] ctr_one_lp  = ctr_width_p'(1);

    typedef enum logic {
        e_init,
        e_ready
    } state_e;

    state_e                     state_q, state_d;
    logic [bht_idx_width_p-1:0] init_idx_q, init_idx_d;
    logic [ctr_width_p-1:0]     ctr_q [els_lp];
    logic [ctr_width_p-1:0]     ctr_d [els_lp];
    logic                       predict_q, predict_d;
    logic                       predict_v_q, predict_v_d;
    logic [ctr_width_p-1:0]     w_ctr;
    logic                       ready;

    // A reset in progress masks the handshake even while the state flop still reads READY.
    assign ready       = (state_q == e_ready) && !reset_i;
    assign w_yumi_o    = ready && w_v_i;
    assign init_done_o = ready;
    assign predict_o   = predict_q;
    assign predict_v_o = predict_v_q;
    assign w_ctr       = ctr_q[idx_w_i];

    always_comb begin
        state_d     = state_q;
        init_idx_d  = init_idx_q;
        ctr_d       = ctr_q;
        predict_d   = predict_q;
        predict_v_d = 1'b0;

        case (state_q)
            e_init: begin
                ctr_d[init_idx_q] = ctr_init_lp;
                init_idx_d        = init_idx_q + 1'b1;
                if (init_idx_q == {bht_idx_width_p{1'b1}}) begin
                    state_d = e_ready;
                end
            end
            e_ready: begin
                // Read samples ctr_q, so a same-index update returns the old counter.
                if (r_v_i) begin
                    predict_v_d = 1'b1;
                    predict_d   = ctr_q[idx_r_i][ctr_width_p-1];
                end
                if (w_v_i) begin
                    if (taken_i) begin
                        ctr_d[idx_w_i] = (w_ctr == ctr_max_lp) ? w_ctr : w_ctr + ctr_one_lp;
                    end else begin
                        ctr_d[idx_w_i] = (w_ctr == '0) ? w_ctr : w_ctr - ctr_one_lp;
                    end
                end
            end
            default: begin
                state_d = e_init;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= e_init;
            init_idx_q  <= '0;
            predict_q   <= 1'b0;
            predict_v_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_idx_q  <= init_idx_d;
            predict_q   <= predict_d;
            predict_v_q <= predict_v_d;
        end
    end

    // Table contents need no reset: initialisation rewrites every entry.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            ctr_q <= ctr_d;
        end
    end

endmodule

// File: tb/tb_bp_fe_bp_bimodal.sv
// tb/tb_bp_fe_bp_bimodal.sv - scoreboard bench for bp_fe_bp_bimodal
module tb_bp_fe_bp_bimodal;

    localparam int iw_lp = 4;
    localparam int cw_lp = 2;
    localparam int n_lp  = 1 << iw_lp;

    logic             clk = 1'b0;
    logic             reset_i = 1'b1;
    logic             r_v_i = 1'b0;
    logic [iw_lp-1:0] idx_r_i = '0;
    logic             predict_o;
    logic             predict_v_o;
    logic             w_v_i = 1'b0;
    logic [iw_lp-1:0] idx_w_i = '0;
    logic             taken_i = 1'b0;
    logic             w_yumi_o;
    logic             init_done_o;

    always #5 clk = ~clk;

    bp_fe_bp_bimodal #(
        .bht_idx_width_p(iw_lp),
        .ctr_width_p    (cw_lp)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .r_v_i      (r_v_i),
        .idx_r_i    (idx_r_i),
        .predict_o  (predict_o),
        .predict_v_o(predict_v_o),
        .w_v_i      (w_v_i),
        .idx_w_i    (idx_w_i),
        .taken_i    (taken_i),
        .w_yumi_o   (w_yumi_o),
        .init_done_o(init_done_o)
    );

    int model_ctr [n_lp];
    bit model_ready = 1'b0;
    int model_cnt   = 0;
    int last_pred   = 0;
    int exp_q [$];
    int n_checks    = 0;
    int n_errors    = 0;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit rv, input int ri,
                        input bit wv, input int wi, input bit tk);
        bit ev;
        int ec;
        @(negedge clk);
        reset_i = rst;
        r_v_i   = rv;
        idx_r_i = ri[iw_lp-1:0];
        w_v_i   = wv;
        idx_w_i = wi[iw_lp-1:0];
        taken_i = tk;
        #1;
        check_eq("w_yumi", int'(w_yumi_o), int'(model_ready && wv && !rst));
        ev = model_ready && rv && !rst;
        if (ev) exp_q.push_back((model_ctr[ri] >= 2) ? 1 : 0);
        @(posedge clk);
        if (rst) begin
            model_ready = 1'b0;
            model_cnt   = 0;
            foreach (model_ctr[i]) model_ctr[i] = 1;
        end else if (!model_ready) begin
            model_cnt++;
            if (model_cnt == n_lp) model_ready = 1'b1;
        end else if (wv) begin
            if (tk) model_ctr[wi] = (model_ctr[wi] == 3) ? 3 : model_ctr[wi] + 1;
            else    model_ctr[wi] = (model_ctr[wi] == 0) ? 0 : model_ctr[wi] - 1;
        end
        #1;
        check_eq("init_done", int'(init_done_o), int'(model_ready));
        check_eq("predict_v", int'(predict_v_o), int'(ev));
        if (rst) begin
            last_pred = 0;
            check_eq("predict_reset", int'(predict_o), 0);
        end else if (ev) begin
            ec = exp_q.pop_front();
            last_pred = ec;
            check_eq($sformatf("predict[%0d]", ri), int'(predict_o), ec);
        end else begin
            check_eq("predict_hold", int'(predict_o), last_pred);
        end
    endtask

    task automatic rd(input int i);
        step(0, 1, i, 0, 0, 0);
    endtask

    task automatic wr(input int i, input bit tk);
        step(0, 0, 0, 1, i, tk);
    endtask

    initial begin
        int cyc;
        foreach (model_ctr[i]) model_ctr[i] = 1;

        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 1);

        // Requests held during init must be neither accepted nor answered.
        cyc = 0;
        while (!init_done_o && cyc < 40) begin
            step(0, 1, cyc % n_lp, 1, 0, 1);
            cyc++;
        end
        check_eq("init_cycles", cyc, n_lp);

        for (int i = 0; i < n_lp; i++) rd(i);
        step(0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 4; k++) begin
            wr(5, 1);
            rd(5);
        end
        for (int k = 0; k < 2; k++) begin
            wr(5, 0);
            rd(5);
        end

        for (int k = 0; k < 3; k++) begin
            wr(7, 0);
            rd(7);
        end
        wr(7, 1);
        rd(7);

        step(0, 1, 3, 1, 3, 1);
        rd(3);

        step(0, 1, 4, 1, 6, 1);
        rd(6);
        rd(4);

        wr(2, 1);
        wr(2, 1);
        rd(2);
        step(1, 0, 0, 0, 0, 0);
        cyc = 0;
        while (!init_done_o && cyc < 40) begin
            step(0, 1, 2, 1, 2, 1);
            cyc++;
        end
        check_eq("reinit_cycles", cyc, n_lp);
        rd(2);
        rd(5);

        // Reset landing mid-initialisation restarts the full sweep.
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        cyc = 0;
        while (!init_done_o && cyc < 40) begin
            step(0, 0, 0, 0, 0, 0);
            cyc++;
        end
        check_eq("midinit_cycles", cyc, n_lp);
        rd(15);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
